de_pipeline_reg: RTL and testbench
==================================

DE_PIPELINE_REG -- requirements
Module: de_pipeline_reg

Interface
REQ-001 The block SHALL have the parameters `OPCODEWIDTH` (default 4, opcode width), `DATAWIDTH` (default 32, operand width), `REGADDRWIDTH` (default 4, register index width) and `NOP_OPCODE` (default 0, bubble opcode, never a branch opcode).
REQ-002 The clock SHALL be `clk`, input, 1 bit; the block uses one clock and all state updates on its rising edge.
REQ-003 The reset SHALL be `rst`, input, 1 bit; reset is synchronous and active-high.
REQ-004 `stallE` SHALL be an input, 1 bit: hold the D->E register contents.
REQ-005 `takeBranchE` SHALL be an input, 1 bit: branch taken in E, so the instruction in D is squashed.
REQ-006 The decode-side control inputs SHALL be `writeEnableDD`, `writeDataEnableMD`, `resultSelectorWBD`, `data2SelectorED` and `outFlagD`, each 1 bit.
REQ-007 `aluControlED` SHALL be an input, 3 bits; `opcodeD` SHALL be an input, `OPCODEWIDTH` bits; `validD` SHALL be an input, 1 bit (D holds a real instruction).
REQ-008 The decode-side data inputs SHALL be `rd1D` and `rd2D` (`DATAWIDTH` bits, register file reads), `extImmD` (`DATAWIDTH` bits, extended immediate) and `rdD` (`REGADDRWIDTH` bits, destination register).
REQ-009 `aluNE`, `aluZE`, `aluVE` and `aluCE` SHALL be inputs, 1 bit each: the ALU flags of the instruction currently in E.
REQ-010 The E-suffixed outputs SHALL be `writeEnableE`, `writeDataEnableE`, `resultSelectorE`, `data2SelectorE`, `outFlagE`, `aluControlE[2:0]`, `opcodeE`, `rd1E`, `rd2E`, `extImmE`, `rdE` and `validE`: the registered copies of the matching D inputs.
REQ-011 `NE2`, `ZE2`, `VE2` and `CE2` SHALL be outputs, 1 bit each: the architectural flag register, consumed by the conditional unit.
REQ-012 `bubbleCount` SHALL be an output, 16 bits: a saturating count of squashed cycles.

Function
REQ-013 Priority at each rising edge SHALL be `rst` > `takeBranchE` (flush) > `stallE` (hold) > load.
REQ-014 On load, every E output SHALL take its matching D input, giving 1-cycle latency.
REQ-015 On flush, the register SHALL load a bubble: all control outputs 0, `aluControlE`=0, `opcodeE`=`NOP_OPCODE`, `validE`=0 and `rdE`=0; data outputs may keep any value.
REQ-016 On hold, all E outputs SHALL keep their values.
REQ-017 `takeBranchE` together with `stallE` SHALL resolve as a flush.
REQ-018 All E outputs SHALL be driven directly from flops, with no combinational path from D inputs.
REQ-019 Flag update: when `validE`=1, `outFlagE`=1 and `stallE`=0, the next edge SHALL load `{NE2,ZE2,VE2,CE2}` from `{aluNE,aluZE,aluVE,aluCE}`; otherwise the flags SHALL hold.
REQ-020 The flag update SHALL NOT be gated by `takeBranchE`, because the branching instruction itself may set flags.
REQ-021 A flag written at edge N SHALL be visible on `NE2`..`CE2` from edge N, so the next instruction in E sees it with no bypass.
REQ-022 `bubbleCount` SHALL increment by 1 on each edge where a flush occurs while `validD`=1.
REQ-023 `bubbleCount` SHALL saturate at 16'hFFFF and never wrap.
REQ-024 A flush with `validD`=0 SHALL NOT increment `bubbleCount`.
REQ-025 The block SHALL contain no other state: two implicit states, VALID_E and BUBBLE_E, tracked by `validE`.

Reset
REQ-026 While `rst`=1 at an edge, the block SHALL force the bubble state of REQ-015 and set `rd1E`=`rd2E`=`extImmE`=0.
REQ-027 While `rst`=1 at an edge, the block SHALL clear `NE2`..`CE2` to 0 and `bubbleCount` to 0.
REQ-028 `rst` SHALL override `stallE`, `takeBranchE` and the flag update in the same cycle.
REQ-029 Reset asserted mid-stall SHALL discard the held instruction.

Verification
REQ-030 Reset then load: hold `rst` for 2 cycles, then apply `opcodeD`=4'h3, `aluControlED`=3'b010, `rd1D`=32'h5, `validD`=1 -> one cycle later `opcodeE`=4'h3, `aluControlE`=3'b010, `rd1E`=5, `validE`=1; during reset all outputs are 0 and `opcodeE`=`NOP_OPCODE`.
REQ-031 Stall: with E loaded with `opcodeE`=4'h3, hold `stallE`=1 for 3 cycles while D changes to 4'h7 -> `opcodeE` stays 4'h3; after release `opcodeE`=4'h7.
REQ-032 Flush with stall: assert `takeBranchE`=1 and `stallE`=1 together with `validD`=1 -> next cycle `validE`=0, `writeEnableE`=0, `opcodeE`=`NOP_OPCODE`, and `bubbleCount` goes 0->1.
REQ-033 Flags: with `validE`=1, `outFlagE`=1 and ALU flags Z=1, C=1 -> next cycle `ZE2`=1, `CE2`=1, `NE2`=0, `VE2`=0; a following instruction with `outFlagE`=0 and ALU flags N=1 leaves the flags unchanged; a bubble in E leaves the flags unchanged.
REQ-034 Saturation: preload `bubbleCount` to 16'hFFFE by forcing 65534 flushes, then apply 3 more flushes -> `bubbleCount` reads 16'hFFFF and holds; a flush with `validD`=0 does not change the count.
REQ-035 Reset mid-operation: with flags=4'b1111 and `stallE`=1, assert `rst` for one cycle -> flags=0, `bubbleCount`=0, `validE`=0.

Source files
------------

// File: rtl/de_pipeline_reg.sv
// Decode->Execute pipeline register with branch flush, stall hold, the architectural
// NZVC flag register and a saturating count of squashed real instructions.
module de_pipeline_reg #(
  parameter int                     OPCODEWIDTH  = 4,
  parameter int                     DATAWIDTH    = 32,
  parameter int                     REGADDRWIDTH = 4,
  parameter logic [OPCODEWIDTH-1:0] NOP_OPCODE   = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stallE,
  input  logic                    takeBranchE,
  input  logic                    writeEnableDD,
  input  logic                    writeDataEnableMD,
  input  logic                    resultSelectorWBD,
  input  logic                    data2SelectorED,
  input  logic                    outFlagD,
  input  logic [2:0]              aluControlED,
  input  logic [OPCODEWIDTH-1:0]  opcodeD,
  input  logic                    validD,
  input  logic [DATAWIDTH-1:0]    rd1D,
  input  logic [DATAWIDTH-1:0]    rd2D,
  input  logic [DATAWIDTH-1:0]    extImmD,
  input  logic [REGADDRWIDTH-1:0] rdD,
  input  logic                    aluNE,
  input  logic                    aluZE,
  input  logic                    aluVE,
  input  logic                    aluCE,
  output logic                    writeEnableE,
  output logic                    writeDataEnableE,
  output logic                    resultSelectorE,
  output logic                    data2SelectorE,
  output logic                    outFlagE,
  output logic [2:0]              aluControlE,
  output logic [OPCODEWIDTH-1:0]  opcodeE,
  output logic [DATAWIDTH-1:0]    rd1E,
  output logic [DATAWIDTH-1:0]    rd2E,
  output logic [DATAWIDTH-1:0]    extImmE,
  output logic [REGADDRWIDTH-1:0] rdE,
  output logic                    validE,
  output logic                    NE2,
  output logic                    ZE2,
  output logic                    VE2,
  output logic                    CE2,
  output logic [15:0]             bubbleCount
);

  typedef struct packed {
    logic                    we;
    logic                    wde;
    logic                    rs;
    logic                    d2s;
    logic                    of;
    logic [2:0]              alu;
    logic [OPCODEWIDTH-1:0]  op;
    logic [REGADDRWIDTH-1:0] rd;
    logic                    vld;
  } ctrl_t;

  ctrl_t                 ctrl_q, ctrl_d;
  logic [DATAWIDTH-1:0]  rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [3:0]            flags_q, flags_d;
  logic [15:0]           bc_q, bc_d;

  function automatic ctrl_t bubble_ctrl();
    ctrl_t c;
    c    = '0;
    c.op = NOP_OPCODE;
    return c;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    ctrl_d  = ctrl_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    flags_d = flags_q;
    bc_d    = bc_q;
    // Flush wins over stall; data operands of a squashed slot are don't-care and simply hold.
    if (takeBranchE) begin
      ctrl_d = bubble_ctrl();
      if (validD) bc_d = sat_inc(bc_q);
    end else if (!stallE) begin
      ctrl_d.we  = writeEnableDD;
      ctrl_d.wde = writeDataEnableMD;
      ctrl_d.rs  = resultSelectorWBD;
      ctrl_d.d2s = data2SelectorED;
      ctrl_d.of  = outFlagD;
      ctrl_d.alu = aluControlED;
      ctrl_d.op  = opcodeD;
      ctrl_d.rd  = rdD;
      ctrl_d.vld = validD;
      rd1_d      = rd1D;
      rd2_d      = rd2D;
      imm_d      = extImmD;
    end
    // The branching instruction itself may set flags, so takeBranchE does not gate this.
    if (ctrl_q.vld && ctrl_q.of && !stallE)
      flags_d = {aluNE, aluZE, aluVE, aluCE};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= bubble_ctrl();
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      flags_q <= '0;
      bc_q    <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      flags_q <= flags_d;
      bc_q    <= bc_d;
    end
  end

  assign writeEnableE       = ctrl_q.we;
  assign writeDataEnableE   = ctrl_q.wde;
  assign resultSelectorE    = ctrl_q.rs;
  assign data2SelectorE     = ctrl_q.d2s;
  assign outFlagE           = ctrl_q.of;
  assign aluControlE        = ctrl_q.alu;
  assign opcodeE            = ctrl_q.op;
  assign rdE                = ctrl_q.rd;
  assign validE             = ctrl_q.vld;
  assign rd1E               = rd1_q;
  assign rd2E               = rd2_q;
  assign extImmE            = imm_q;
  assign {NE2, ZE2, VE2, CE2} = flags_q;
  assign bubbleCount        = bc_q;

endmodule

// File: tb/tb_de_pipeline_reg.sv
// Directed bench for de_pipeline_reg: reset, load, stall, flush, flag register,
// saturating bubble counter and reset during a stall.
module tb_de_pipeline_reg;

  localparam logic [3:0] NOP = 4'hF;

  logic        clk = 1'b0;
  logic        rst, stallE, takeBranchE;
  logic        writeEnableDD, writeDataEnableMD, resultSelectorWBD, data2SelectorED, outFlagD;
  logic [2:0]  aluControlED;
  logic [3:0]  opcodeD;
  logic        validD;
  logic [31:0] rd1D, rd2D, extImmD;
  logic [3:0]  rdD;
  logic        aluNE, aluZE, aluVE, aluCE;
  logic        writeEnableE, writeDataEnableE, resultSelectorE, data2SelectorE, outFlagE;
  logic [2:0]  aluControlE;
  logic [3:0]  opcodeE;
  logic [31:0] rd1E, rd2E, extImmE;
  logic [3:0]  rdE;
  logic        validE, NE2, ZE2, VE2, CE2;
  logic [15:0] bubbleCount;
  logic [3:0]  flags;

  int tests = 0;
  int fails = 0;

  assign flags = {NE2, ZE2, VE2, CE2};

  de_pipeline_reg #(
    .OPCODEWIDTH(4), .DATAWIDTH(32), .REGADDRWIDTH(4), .NOP_OPCODE(NOP)
  ) dut (
    .clk(clk), .rst(rst), .stallE(stallE), .takeBranchE(takeBranchE),
    .writeEnableDD(writeEnableDD), .writeDataEnableMD(writeDataEnableMD),
    .resultSelectorWBD(resultSelectorWBD), .data2SelectorED(data2SelectorED),
    .outFlagD(outFlagD), .aluControlED(aluControlED), .opcodeD(opcodeD), .validD(validD),
    .rd1D(rd1D), .rd2D(rd2D), .extImmD(extImmD), .rdD(rdD),
    .aluNE(aluNE), .aluZE(aluZE), .aluVE(aluVE), .aluCE(aluCE),
    .writeEnableE(writeEnableE), .writeDataEnableE(writeDataEnableE),
    .resultSelectorE(resultSelectorE), .data2SelectorE(data2SelectorE),
    .outFlagE(outFlagE), .aluControlE(aluControlE), .opcodeE(opcodeE),
    .rd1E(rd1E), .rd2E(rd2E), .extImmE(extImmE), .rdE(rdE), .validE(validE),
    .NE2(NE2), .ZE2(ZE2), .VE2(VE2), .CE2(CE2), .bubbleCount(bubbleCount)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete (actual running, required finished)");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [3:0] op, input logic [2:0] alu, input logic of,
                       input logic we, input logic vld, input logic [31:0] r1);
    opcodeD = op; aluControlED = alu; outFlagD = of; writeEnableDD = we;
    validD = vld; rd1D = r1;
    writeDataEnableMD = we; resultSelectorWBD = we; data2SelectorED = we;
    rd2D = r1 ^ 32'hA5A5_0000; extImmD = r1 + 32'h100; rdD = r1[3:0] ^ 4'h9;
  endtask

  task automatic test_reset();
    rst = 1'b1; stallE = 1'b1; takeBranchE = 1'b0;
    set_d(4'h6, 3'b111, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
    {aluNE, aluZE, aluVE, aluCE} = 4'b1111;
    step(); step();
    tests++; if (opcodeE !== NOP) begin fails++; $display("FAIL reset_opcode: got %h want %h", opcodeE, NOP); end
    tests++; if (validE !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", validE); end
    tests++; if ({writeEnableE, writeDataEnableE, resultSelectorE, data2SelectorE, outFlagE, aluControlE, rdE} !== 12'h0) begin
      fails++; $display("FAIL reset_ctrl: got %h want 0", {writeEnableE, writeDataEnableE, resultSelectorE, data2SelectorE, outFlagE, aluControlE, rdE}); end
    tests++; if ({rd1E, rd2E, extImmE} !== 96'h0) begin fails++; $display("FAIL reset_data: got %h want 0", {rd1E, rd2E, extImmE}); end
    tests++; if (flags !== 4'b0000) begin fails++; $display("FAIL reset_flags: got %b want 0000", flags); end
    tests++; if (bubbleCount !== 16'h0) begin fails++; $display("FAIL reset_bc: got %h want 0000", bubbleCount); end
    {aluNE, aluZE, aluVE, aluCE} = 4'b0000;
  endtask

  task automatic test_load();
    rst = 1'b0; stallE = 1'b0; takeBranchE = 1'b0;
    set_d(4'h3, 3'b010, 1'b0, 1'b1, 1'b1, 32'h5);
    step();
    tests++; if (opcodeE !== 4'h3) begin fails++; $display("FAIL load_opcode: got %h want 3", opcodeE); end
    tests++; if (aluControlE !== 3'b010) begin fails++; $display("FAIL load_alu: got %b want 010", aluControlE); end
    tests++; if (rd1E !== 32'h5) begin fails++; $display("FAIL load_rd1: got %h want 5", rd1E); end
    tests++; if (validE !== 1'b1) begin fails++; $display("FAIL load_valid: got %b want 1", validE); end
    tests++; if ({rd2E, extImmE, rdE} !== {32'hA5A5_0005, 32'h105, 4'hC}) begin
      fails++; $display("FAIL load_data: got %h %h %h want a5a50005 00000105 c", rd2E, extImmE, rdE); end
    tests++; if ({writeEnableE, writeDataEnableE, resultSelectorE, data2SelectorE, outFlagE} !== 5'b11110) begin
      fails++; $display("FAIL load_ctrl: got %b want 11110", {writeEnableE, writeDataEnableE, resultSelectorE, data2SelectorE, outFlagE}); end
  endtask

  task automatic test_stall();
    stallE = 1'b1;
    set_d(4'h7, 3'b001, 1'b0, 1'b0, 1'b1, 32'h77);
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (opcodeE !== 4'h3 || rd1E !== 32'h5) begin
        fails++; $display("FAIL stall_hold%0d: got op %h rd1 %h want op 3 rd1 5", i, opcodeE, rd1E); end
    end
    stallE = 1'b0;
    step();
    tests++; if (opcodeE !== 4'h7 || rd1E !== 32'h77 || writeEnableE !== 1'b0) begin
      fails++; $display("FAIL stall_release: got op %h rd1 %h we %b want op 7 rd1 77 we 0", opcodeE, rd1E, writeEnableE); end
  endtask

  task automatic test_flush_stall();
    set_d(4'h5, 3'b100, 1'b1, 1'b1, 1'b1, 32'h9);
    takeBranchE = 1'b1; stallE = 1'b1;
    step();
    tests++; if (validE !== 1'b0 || writeEnableE !== 1'b0 || opcodeE !== NOP) begin
      fails++; $display("FAIL flush_bubble: got v %b we %b op %h want v 0 we 0 op %h", validE, writeEnableE, opcodeE, NOP); end
    tests++; if (rdE !== 4'h0 || aluControlE !== 3'b0 || outFlagE !== 1'b0) begin
      fails++; $display("FAIL flush_ctrl: got rd %h alu %b of %b want 0 0 0", rdE, aluControlE, outFlagE); end
    tests++; if (bubbleCount !== 16'd1) begin fails++; $display("FAIL flush_bc: got %h want 0001", bubbleCount); end
    validD = 1'b0; stallE = 1'b0;
    step();
    tests++; if (bubbleCount !== 16'd1 || validE !== 1'b0) begin
      fails++; $display("FAIL flush_novalid: got bc %h v %b want bc 0001 v 0", bubbleCount, validE); end
    takeBranchE = 1'b0;
  endtask

  task automatic test_flags();
    stallE = 1'b0; takeBranchE = 1'b0;
    set_d(4'h2, 3'b000, 1'b1, 1'b0, 1'b1, 32'h1);
    step();
    {aluNE, aluZE, aluVE, aluCE} = 4'b0101;
    set_d(4'h4, 3'b000, 1'b0, 1'b0, 1'b1, 32'h2);
    step();
    tests++; if (flags !== 4'b0101) begin fails++; $display("FAIL flags_set: got %b want 0101", flags); end
    {aluNE, aluZE, aluVE, aluCE} = 4'b1000;
    set_d(4'h2, 3'b000, 1'b1, 1'b0, 1'b1, 32'h3);
    takeBranchE = 1'b1;
    step();
    tests++; if (flags !== 4'b0101) begin fails++; $display("FAIL flags_noout: got %b want 0101", flags); end
    takeBranchE = 1'b0;
    {aluNE, aluZE, aluVE, aluCE} = 4'b1010;
    set_d(4'h2, 3'b000, 1'b1, 1'b0, 1'b1, 32'h4);
    step();
    tests++; if (flags !== 4'b0101) begin fails++; $display("FAIL flags_bubble: got %b want 0101", flags); end
    {aluNE, aluZE, aluVE, aluCE} = 4'b1111;
    stallE = 1'b1;
    step();
    tests++; if (flags !== 4'b0101) begin fails++; $display("FAIL flags_stall: got %b want 0101", flags); end
    stallE = 1'b0; takeBranchE = 1'b1;
    step();
    tests++; if (flags !== 4'b1111) begin fails++; $display("FAIL flags_branch: got %b want 1111", flags); end
    tests++; if (bubbleCount !== 16'd3) begin fails++; $display("FAIL flags_bc: got %h want 0003", bubbleCount); end
    takeBranchE = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_d(4'h8, 3'b011, 1'b1, 1'b1, 1'b1, 32'h8);
    step();
    tests++; if (validE !== 1'b1 || flags !== 4'b1111) begin
      fails++; $display("FAIL rmid_pre: got v %b flags %b want v 1 flags 1111", validE, flags); end
    stallE = 1'b1; rst = 1'b1;
    step();
    tests++; if (flags !== 4'b0000 || bubbleCount !== 16'h0 || validE !== 1'b0) begin
      fails++; $display("FAIL rmid_reset: got flags %b bc %h v %b want 0000 0000 0", flags, bubbleCount, validE); end
    rst = 1'b0;
    step();
    tests++; if (validE !== 1'b0 || opcodeE !== NOP) begin
      fails++; $display("FAIL rmid_discard: got v %b op %h want v 0 op %h", validE, opcodeE, NOP); end
    stallE = 1'b0;
  endtask

  task automatic test_saturation();
    rst = 1'b0; stallE = 1'b0; takeBranchE = 1'b1;
    set_d(4'h1, 3'b000, 1'b0, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 65534; i++) @(posedge clk);
    #1;
    tests++; if (bubbleCount !== 16'hFFFE) begin fails++; $display("FAIL sat_preload: got %h want fffe", bubbleCount); end
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (bubbleCount !== 16'hFFFF) begin fails++; $display("FAIL sat_flush%0d: got %h want ffff", i, bubbleCount); end
    end
    validD = 1'b0;
    step();
    tests++; if (bubbleCount !== 16'hFFFF) begin fails++; $display("FAIL sat_novalid: got %h want ffff", bubbleCount); end
    takeBranchE = 1'b0; validD = 1'b1;
    step();
    tests++; if (bubbleCount !== 16'hFFFF || validE !== 1'b1) begin
      fails++; $display("FAIL sat_load: got bc %h v %b want ffff 1", bubbleCount, validE); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_stall();
    test_flush_stall();
    test_flags();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
